// File: rtl/packet_switch.sv
`default_nettype none
// ============================================================================
//  Module      : packet_switch
//  Description : Single-packet output-port switch with programmable address table.
//  Revision    : 1.0
// ============================================================================
module packet_switch #(
    parameter int NUM_OF_PORTS     = 10,
    parameter int PORT_ADDR_LENGTH = 8,
    parameter int DATA_WIDTH       = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [$clog2(NUM_OF_PORTS)-1:0]    mem_port_index,
    input  logic [PORT_ADDR_LENGTH-1:0]        port_address,
    input  logic                               mem_write,
    input  logic [DATA_WIDTH-1:0]              packet_data,
    input  logic                               packet_send_req,
    output logic                               packet_finished,
    output logic [NUM_OF_PORTS-1:0]            port_req,
    output logic [NUM_OF_PORTS*DATA_WIDTH-1:0] port_data,
    input  logic [NUM_OF_PORTS-1:0]            port_received
);

    localparam int c_IDX_W = $clog2(NUM_OF_PORTS);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [PORT_ADDR_LENGTH-1:0] r_table [NUM_OF_PORTS];
    logic [0:0]                  r_state;
    logic [c_IDX_W-1:0]          r_target;
    logic [DATA_WIDTH-1:0]       r_packet;

    logic [NUM_OF_PORTS-1:0]     w_table_hit;
    logic [NUM_OF_PORTS-1:0]     w_sel;
    logic                        w_hit;
    logic [c_IDX_W-1:0]          w_hit_idx;
    logic                        w_dup;
    logic                        w_idx_ok;
    logic                        w_write_ok;

    for (genvar i = 0; i < NUM_OF_PORTS; i++) begin : g_port
        assign w_table_hit[i] = (r_table[i] == port_address);
        assign w_sel[i]       = (r_state == c_BUSY) && (r_target == c_IDX_W'(i));
        assign port_req[i]    = w_sel[i];
        assign port_data[i*DATA_WIDTH +: DATA_WIDTH] = w_sel[i] ? r_packet : '0;
    end

    assign packet_finished = |(w_sel & port_received);

    // Address 0 marks an unassigned entry, so it can never produce a hit.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_OF_PORTS - 1; i >= 0; i--) begin
            if (w_table_hit[i] && (port_address != '0)) begin
                w_hit     = 1'b1;
                w_hit_idx = c_IDX_W'(i);
            end
        end
    end

    // Rewriting an entry with its own current address is not a duplicate.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            if (w_table_hit[i] && (c_IDX_W'(i) != mem_port_index)) begin
                w_dup = 1'b1;
            end
        end
    end

    assign w_idx_ok   = (32'(mem_port_index) < NUM_OF_PORTS);
    assign w_write_ok = mem_write && !packet_send_req && (port_address != '0) &&
                        w_idx_ok && !w_dup;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OF_PORTS; i++) begin
                r_table[i] <= '0;
            end
            r_state  <= c_IDLE;
            r_target <= '0;
            r_packet <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (packet_send_req && w_hit) begin
                        r_state  <= c_BUSY;
                        r_target <= w_hit_idx;
                        r_packet <= packet_data;
                    end
                    if (w_write_ok) begin
                        r_table[mem_port_index] <= port_address;
                    end
                end
                c_BUSY: begin
                    if (packet_finished) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_switch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_switch
//  Description : Scoreboard bench for packet_switch with a queue-based reference model.
//  Revision    : 1.0
// ============================================================================
module tb_packet_switch;

    localparam int N  = 10;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int IW = $clog2(N);

    typedef struct {
        int             idx;
        logic [DW-1:0]  data;
    } xfer_t;

    logic              clk;
    logic              reset;
    logic [IW-1:0]     mem_port_index;
    logic [AW-1:0]     port_address;
    logic              mem_write;
    logic [DW-1:0]     packet_data;
    logic              packet_send_req;
    logic              packet_finished;
    logic [N-1:0]      port_req;
    logic [N*DW-1:0]   port_data;
    logic [N-1:0]      port_received;

    int errors = 0;
    int checks = 0;

    xfer_t exp_xfer[$];
    int    exp_fin[$];

    int    m_table[N];
    bit    m_busy;
    int    m_target;

    packet_switch #(
        .NUM_OF_PORTS     (N),
        .PORT_ADDR_LENGTH (AW),
        .DATA_WIDTH       (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_port_index  (mem_port_index),
        .port_address    (port_address),
        .mem_write       (mem_write),
        .packet_data     (packet_data),
        .packet_send_req (packet_send_req),
        .packet_finished (packet_finished),
        .port_req        (port_req),
        .port_data       (port_data),
        .port_received   (port_received)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [N*DW-1:0] data_vec(input int idx, input logic [DW-1:0] d);
        logic [N*DW-1:0] v;
        v = '0;
        if (idx >= 0) v[idx*DW +: DW] = d;
        return v;
    endfunction

    // Reference model: predicts what the next clock edge does to the table and transfer.
    task automatic model_step();
        int  hit;
        bit  taken;
        if (!reset) begin
            foreach (m_table[i]) m_table[i] = 0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (port_received[m_target]) begin
                exp_fin.push_back(m_target);
                m_busy = 1'b0;
            end
        end else if (packet_send_req) begin
            hit = -1;
            if (port_address != 0) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (m_table[i] == int'(port_address)) hit = i;
                end
            end
            if (hit >= 0) begin
                xfer_t x;
                x.idx  = hit;
                x.data = packet_data;
                exp_xfer.push_back(x);
                m_busy   = 1'b1;
                m_target = hit;
            end
        end else if (mem_write) begin
            taken = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i != int'(mem_port_index) && m_table[i] == int'(port_address)) taken = 1'b1;
            end
            if (port_address != 0 && int'(mem_port_index) < N && !taken)
                m_table[mem_port_index] = int'(port_address);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic op_write(input int idx, input int addr);
        mem_write      = 1'b1;
        mem_port_index = IW'(idx);
        port_address   = AW'(addr);
        cyc();
        mem_write = 1'b0;
    endtask

    task automatic op_send(input int addr, input int d);
        packet_send_req = 1'b1;
        port_address    = AW'(addr);
        packet_data     = DW'(d);
        cyc();
        packet_send_req = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int idx, input int d, input bit fin);
        #1;
        chk({tag, "_req"},  port_req,        onehot(idx));
        chk({tag, "_data"}, port_data,       data_vec(idx, DW'(d)));
        chk({tag, "_fin"},  packet_finished, fin);
    endtask

    // Monitor: pops an expected transfer whenever a new request appears on the ports.
    bit    mon_active = 1'b0;
    xfer_t mon_cur;
    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && port_req != '0) begin
                if (exp_xfer.size() == 0) begin
                    chk("unexpected_req", port_req, '0);
                end else begin
                    mon_cur    = exp_xfer.pop_front();
                    mon_active = 1'b1;
                    chk("xfer_req",  port_req,  onehot(mon_cur.idx));
                    chk("xfer_data", port_data, data_vec(mon_cur.idx, mon_cur.data));
                end
            end else if (mon_active) begin
                chk("hold_req",  port_req,  onehot(mon_cur.idx));
                chk("hold_data", port_data, data_vec(mon_cur.idx, mon_cur.data));
            end else begin
                chk("idle_data", port_data, '0);
            end
            if (packet_finished) begin
                if (exp_fin.size() == 0) begin
                    chk("unexpected_fin", packet_finished, 1'b0);
                end else begin
                    int f;
                    f = exp_fin.pop_front();
                    chk("fin_port", mon_active ? mon_cur.idx : -1, f);
                end
                mon_active = 1'b0;
            end
        end
    end

    logic [AW-1:0] pool [8] = '{8'd0, 8'd13, 8'd42, 8'd69, 8'd99, 8'd1, 8'd2, 8'd3};

    initial begin
        reset           = 1'b0;
        mem_port_index  = '0;
        port_address    = '0;
        mem_write       = 1'b0;
        packet_data     = '0;
        packet_send_req = 1'b0;
        port_received   = '0;
        m_busy          = 1'b0;
        m_target        = 0;
        foreach (m_table[i]) m_table[i] = 0;

        @(posedge clk);
        #1;
        repeat (10) cyc();
        expect_out("reset", -1, 0, 1'b0);
        reset = 1'b1;
        cyc();
        op_send(42, 8'h11);
        expect_out("send_after_reset", -1, 0, 1'b0);

        // Basic send and completion
        op_write(3, 42);
        op_send(42, 8'h45);
        expect_out("basic", 3, 8'h45, 1'b0);
        port_received = onehot(2);
        expect_out("wrong_ack", 3, 8'h45, 1'b0);
        cyc();
        port_received = onehot(3);
        expect_out("ack", 3, 8'h45, 1'b1);
        cyc();
        port_received = '0;
        expect_out("after_ack", -1, 0, 1'b0);

        // Unknown address, duplicate and rewrite
        op_send(69, 8'h22);
        expect_out("unknown", -1, 0, 1'b0);
        cyc();
        op_write(4, 42);
        op_write(3, 13);
        op_send(42, 8'h33);
        expect_out("dup_rewrite", -1, 0, 1'b0);

        // Write while busy is ignored
        op_send(13, 8'hA7);
        expect_out("busy13", 3, 8'hA7, 1'b0);
        op_write(5, 69);
        port_received = onehot(3);
        cyc();
        port_received = '0;
        op_send(69, 8'h44);
        expect_out("write_in_busy", -1, 0, 1'b0);

        // Illegal writes
        op_write(1, 0);
        op_write(12, 5);
        op_send(5, 8'h55);
        expect_out("idx12", -1, 0, 1'b0);
        op_send(0, 8'h66);
        expect_out("addr0", -1, 0, 1'b0);

        // Acknowledge already high when BUSY is entered
        op_write(7, 99);
        port_received = onehot(7);
        op_send(99, 8'h5A);
        expect_out("persist", 7, 8'h5A, 1'b1);
        cyc();
        port_received = '0;
        expect_out("persist_done", -1, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            packet_send_req = ($urandom_range(0, 3) == 0);
            mem_write       = ($urandom_range(0, 2) == 0);
            mem_port_index  = IW'($urandom_range(0, 15));
            port_address    = pool[$urandom_range(0, 7)];
            packet_data     = DW'($urandom);
            port_received   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cyc();
        end
        packet_send_req = 1'b0;
        mem_write       = 1'b0;
        port_received   = '1;
        repeat (3) cyc();
        port_received   = '0;
        cyc();
        #6;
        chk("xfer_queue_empty", exp_xfer.size(), 0);
        chk("fin_queue_empty",  exp_fin.size(),  0);

        // Reset aborts a transfer and clears the table
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        op_write(3, 13);
        op_send(13, 8'hC3);
        expect_out("pre_abort", 3, 8'hC3, 1'b0);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        expect_out("abort", -1, 0, 1'b0);
        op_send(13, 8'hC4);
        expect_out("abort_table", -1, 0, 1'b0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
